// File: rtl/regfile_port_sequencer.sv
// Initiator-side sequencer for a 32x64 register file with an always-writing write port.
// Optional commit counters are compiled in when REGFILE_SEQ_PERF_EN is defined.
//
// state | meaning
// IDLE  | parked, accepting a write (priority) or a read-pair request
// WRITE | write select/data driven; the register file commits at the closing edge
// READ  | read selects stable; outputs captured at the closing edge
// RESP  | response held until consumed
module regfile_port_sequencer (
   input  logic        clock,
   input  logic        reset,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [4:0]  wr_addr,
   input  logic [63:0] wr_data,
   input  logic        rd_valid,
   output logic        rd_ready,
   input  logic [4:0]  rd_addr_a,
   input  logic [4:0]  rd_addr_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_data_a,
   output logic [63:0] rsp_data_b,
   output logic [63:0] rf_data_in,
   output logic [4:0]  rf_wsel,
   output logic [4:0]  rf_rsel_a,
   output logic [4:0]  rf_rsel_b,
   input  logic [63:0] rf_out_a,
   input  logic [63:0] rf_out_b,
   output logic [15:0] wr_count,
   output logic [15:0] rd_count
);

   localparam logic [4:0] PARK_REG = 5'd31;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WRITE = 2'd1;
   localparam logic [1:0] READ  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0] state;

   assign wr_ready = (state == IDLE);
   assign rd_ready = (state == IDLE) && !wr_valid;

   // Async reset parks the write port at once, so an uncommitted write is lost.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         rf_wsel    <= PARK_REG;
         rf_data_in <= '0;
         rf_rsel_a  <= '0;
         rf_rsel_b  <= '0;
         rsp_valid  <= 1'b0;
         rsp_data_a <= '0;
         rsp_data_b <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_valid) begin
                  rf_wsel    <= wr_addr;
                  rf_data_in <= wr_data;
                  state      <= WRITE;
               end else if (rd_valid) begin
                  rf_rsel_a <= rd_addr_a;
                  rf_rsel_b <= rd_addr_b;
                  state     <= READ;
               end
            end
            WRITE: begin
               rf_wsel    <= PARK_REG;
               rf_data_in <= '0;
               state      <= IDLE;
            end
            READ: begin
               // The sink register is written every idle cycle; never expose its contents.
               rsp_data_a <= (rf_rsel_a == PARK_REG) ? 64'd0 : rf_out_a;
               rsp_data_b <= (rf_rsel_b == PARK_REG) ? 64'd0 : rf_out_b;
               rsp_valid  <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef REGFILE_SEQ_PERF_EN
   logic [15:0] wrCountQ;
   logic [15:0] rdCountQ;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wrCountQ <= '0;
         rdCountQ <= '0;
      end else begin
         if (state == WRITE) wrCountQ <= wrCountQ + 16'd1;
         if ((state == RESP) && rsp_ready) rdCountQ <= rdCountQ + 16'd1;
      end
   end

   assign wr_count = wrCountQ;
   assign rd_count = rdCountQ;
`else
   assign wr_count = 16'd0;
   assign rd_count = 16'd0;
`endif

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Bench for regfile_port_sequencer: register-file environment, transaction-level
// reference model with per-cycle compare, and directed scenarios with literal checks.
module tb_regfile_port_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [4:0]  wr_addr = '0;
   logic [63:0] wr_data = '0;
   logic        rd_valid = 1'b0;
   logic        rd_ready;
   logic [4:0]  rd_addr_a = '0;
   logic [4:0]  rd_addr_b = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [63:0] rsp_data_a, rsp_data_b;
   logic [63:0] rf_data_in;
   logic [4:0]  rf_wsel, rf_rsel_a, rf_rsel_b;
   logic [63:0] rf_out_a, rf_out_b;
   logic [15:0] wr_count, rd_count;

   int nChecks = 0;
   int nPass = 0;

   regfile_port_sequencer dut (
      .clock(clock), .reset(reset),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b),
      .rf_data_in(rf_data_in), .rf_wsel(rf_wsel), .rf_rsel_a(rf_rsel_a), .rf_rsel_b(rf_rsel_b),
      .rf_out_a(rf_out_a), .rf_out_b(rf_out_b), .wr_count(wr_count), .rd_count(rd_count)
   );

   always #5 clock = ~clock;

   function automatic logic [63:0] pat(input int i);
      return {32'hA5A5_0000 | 32'(i), 32'h0000_1000 + 32'(i)};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Register file environment: writes every clock, reads combinationally.
   logic [63:0] rfArr [32];
   logic envInit = 1'b0;
   always @(posedge clock) begin
      if (!envInit) begin
         for (int i = 0; i < 32; i++) rfArr[i] <= pat(i);
         envInit <= 1'b1;
      end else begin
         rfArr[rf_wsel] <= rf_data_in;
      end
   end
   assign rf_out_a = rfArr[rf_rsel_a];
   assign rf_out_b = rfArr[rf_rsel_b];

   // Reference model: one outstanding request at a time, memory updated on commit.
   // mPhase: 0 free, 1 write in flight, 2 read in flight, 3 response pending
   int          mPhase;
   logic [4:0]  mWa, mRa, mRb;
   logic [63:0] mWd, mRspA, mRspB;
   logic [63:0] mMem [32];
   int          mWc, mRc;
   logic        mInit = 1'b0;
   logic        fWr, fRd, fRsp;
   logic [4:0]  sWa, sRa, sRb;
   logic [63:0] sWd;

   always @(posedge clock or posedge reset) begin
      if (!mInit) begin
         for (int i = 0; i < 32; i++) mMem[i] = pat(i);
         mInit = 1'b1;
      end
      if (reset) begin
         mPhase = 0; mRa = '0; mRb = '0; mRspA = '0; mRspB = '0; mWc = 0; mRc = 0;
      end else begin
         case (mPhase)
            0: if (fWr) begin mWa = sWa; mWd = sWd; mPhase = 1; end
               else if (fRd) begin mRa = sRa; mRb = sRb; mPhase = 2; end
            1: begin
               if (mWa != 5'd31) mMem[mWa] = mWd;
               mWc++; mPhase = 0;
            end
            2: begin
               mRspA = (mRa == 5'd31) ? 64'd0 : mMem[mRa];
               mRspB = (mRb == 5'd31) ? 64'd0 : mMem[mRb];
               mPhase = 3;
            end
            default: if (fRsp) begin mRc++; mPhase = 0; end
         endcase
      end
   end

   always @(negedge clock) begin
      fWr = 1'b0; fRd = 1'b0; fRsp = 1'b0;
      if (!reset) begin
         fWr  = (mPhase == 0) && wr_valid;
         fRd  = (mPhase == 0) && !wr_valid && rd_valid;
         fRsp = (mPhase == 3) && rsp_ready;
         sWa = wr_addr; sWd = wr_data; sRa = rd_addr_a; sRb = rd_addr_b;
         check("wr_ready", wr_ready, (mPhase == 0));
         check("rd_ready", rd_ready, (mPhase == 0) && !wr_valid);
         check("rsp_valid", rsp_valid, (mPhase == 3));
         check("rf_wsel", rf_wsel, (mPhase == 1) ? mWa : 5'd31);
         check("rf_data_in", rf_data_in, (mPhase == 1) ? mWd : 64'd0);
         check("rf_rsel_a", rf_rsel_a, mRa);
         check("rf_rsel_b", rf_rsel_b, mRb);
         check("rsp_data_a", rsp_data_a, mRspA);
         check("rsp_data_b", rsp_data_b, mRspB);
`ifdef REGFILE_SEQ_PERF_EN
         check("wr_count", wr_count, 64'(mWc % 65536));
         check("rd_count", rd_count, 64'(mRc % 65536));
`else
         check("wr_count", wr_count, 64'd0);
         check("rd_count", rd_count, 64'd0);
`endif
      end
   end

   // Tasks start and end at posedge+1.
   task automatic doWrite(input logic [4:0] a, input logic [63:0] d);
      logic ok = 1'b0;
      wr_valid = 1'b1; wr_addr = a; wr_data = d;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clock);
         if (wr_ready) ok = 1'b1;
      end
      check("wr_hs_timeout", ok, 1'b1);
      @(posedge clock); #1;
      wr_valid = 1'b0;
   endtask

   task automatic issueRead(input logic [4:0] a, input logic [4:0] b);
      logic ok = 1'b0;
      rd_valid = 1'b1; rd_addr_a = a; rd_addr_b = b;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clock);
         if (rd_ready) ok = 1'b1;
      end
      check("rd_hs_timeout", ok, 1'b1);
      @(posedge clock); #1;
      rd_valid = 1'b0;
   endtask

   // Called right after a read handshake; leaves the bench at the negedge where rsp_valid is seen.
   task automatic waitRsp(output int lat, output logic [63:0] da, output logic [63:0] db);
      logic ok = 1'b0;
      lat = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clock);
         if (rsp_valid) ok = 1'b1;
         else begin @(posedge clock); lat++; end
      end
      check("rsp_timeout", ok, 1'b1);
      da = rsp_data_a; db = rsp_data_b;
   endtask

   task automatic doRead(input logic [4:0] a, input logic [4:0] b,
                         output int lat, output logic [63:0] da, output logic [63:0] db);
      rsp_ready = 1'b1;
      issueRead(a, b);
      waitRsp(lat, da, db);
      @(posedge clock); #1;
   endtask

   int lat, edges;
   logic [63:0] da, db;
   logic found;

   initial begin
      repeat (3) @(posedge clock);
      check("reset_wsel", rf_wsel, 5'd31);
      check("reset_rsp_valid", rsp_valid, 1'b0);
      #1 reset = 1'b0;
      @(posedge clock); #1;

      // Write then read back
      doWrite(5'd3, 64'h0123_4567_89AB_CDEF);
      doRead(5'd3, 5'd0, lat, da, db);
      check("wr_rd_a", da, 64'h0123_4567_89AB_CDEF);
      check("wr_rd_b", db, pat(0));
      check("rd_latency", 64'(lat), 64'd1);

      // Simultaneous requests: write wins, read follows two edges later
      wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 64'h7777_0000_1111_2222;
      rd_valid = 1'b1; rd_addr_a = 5'd7; rd_addr_b = 5'd3;
      @(negedge clock);
      check("simul_rd_ready", rd_ready, 1'b0);
      check("simul_wr_ready", wr_ready, 1'b1);
      @(posedge clock); #1;
      wr_valid = 1'b0;
      edges = 0; found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clock);
         if (rd_ready) found = 1'b1;
         else begin @(posedge clock); #1; edges++; end
      end
      check("simul_rd_timeout", found, 1'b1);
      check("simul_rd_edges", 64'(edges + 1), 64'd2);
      @(posedge clock); #1;
      rd_valid = 1'b0;
      waitRsp(lat, da, db);
      @(posedge clock); #1;
      check("simul_rd_a", da, 64'h7777_0000_1111_2222);
      check("simul_rd_b", db, 64'h0123_4567_89AB_CDEF);

      // Park register reads back as zero
      doWrite(5'd31, 64'hFFFF);
      doRead(5'd31, 5'd31, lat, da, db);
      check("park_a", da, 64'd0);
      check("park_b", db, 64'd0);

      // Response backpressure
      doWrite(5'd9, 64'h9999_AAAA_BBBB_CCCC);
      rsp_ready = 1'b0;
      issueRead(5'd9, 5'd7);
      waitRsp(lat, da, db);
      check("bp_a", da, 64'h9999_AAAA_BBBB_CCCC);
      check("bp_b", db, 64'h7777_0000_1111_2222);
      for (int k = 1; k < 5; k++) begin
         @(negedge clock);
         check("bp_valid_hold", rsp_valid, 1'b1);
         check("bp_data_hold", rsp_data_a, 64'h9999_AAAA_BBBB_CCCC);
         check("bp_wr_ready", wr_ready, 1'b0);
         check("bp_rd_ready", rd_ready, 1'b0);
      end
      @(posedge clock); #1;
      rsp_ready = 1'b1;
      @(negedge clock);
      check("bp_valid_before_retire", rsp_valid, 1'b1);
      @(posedge clock); #1;
      @(negedge clock);
      check("bp_retired", rsp_valid, 1'b0);
      @(posedge clock); #1;

      // Reset during a write: the write never commits
      doWrite(5'd5, 64'hDEAD);
      #1 reset = 1'b1;
      #1;
      check("rst_wsel_async", rf_wsel, 5'd31);
      check("rst_data_async", rf_data_in, 64'd0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_wr_ready", wr_ready, 1'b1);
      @(posedge clock); #1;
      reset = 1'b0;
      check("rst_reg5_kept", rfArr[5], pat(5));

      // Counters: 3 writes, 2 reads since reset
      doWrite(5'd1, 64'h1111);
      doWrite(5'd2, 64'h2222);
      doWrite(5'd31, 64'h3333);
      doRead(5'd5, 5'd1, lat, da, db);
      check("cnt_rd_a", da, pat(5));
      check("cnt_rd_b", db, 64'h1111);
      doRead(5'd2, 5'd31, lat, da, db);
      check("cnt_rd2_a", da, 64'h2222);
      check("cnt_rd2_b", db, 64'd0);
      @(negedge clock);
`ifdef REGFILE_SEQ_PERF_EN
      check("wr_count_lit", wr_count, 64'd3);
      check("rd_count_lit", rd_count, 64'd2);
`else
      check("wr_count_lit", wr_count, 64'd0);
      check("rd_count_lit", rd_count, 64'd0);
`endif
      @(posedge clock); #1;

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
